// File: rtl/bids22_pkg.sv
// Shared types for the BIDS22 auction controller: opcodes, FSM states and
// status codes seen on the host and bidder ports.
package bids22_pkg;

  typedef enum logic [3:0] {
    OP_NOOP         = 4'd0,
    OP_UNLOCK       = 4'd1,
    OP_LOCK         = 4'd2,
    OP_LOADX        = 4'd3,
    OP_LOADY        = 4'd4,
    OP_LOADZ        = 4'd5,
    OP_SETMASK      = 4'd6,
    OP_SETTIMER     = 4'd7,
    OP_BIDCHARGE    = 4'd8,
    OP_ROUNDACTIVE  = 4'd9,
    OP_ROUNDOVER    = 4'd10
  } operation_t;

  typedef enum logic [1:0] {
    ST_UNLOCKED     = 2'd0,
    ST_LOCKED       = 2'd1,
    ST_ROUND_ACTIVE = 2'd2,
    ST_COOLDOWN     = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CE_OK               = 3'b000,
    CE_BAD_KEY          = 3'b001,
    CE_ALREADY_UNLOCKED = 3'b010,
    CE_ALREADY_LOCKED   = 3'b011,
    CE_INVALID_OP       = 3'b100,
    CE_BUSY             = 3'b101,
    CE_BAD_OPCODE       = 3'b110
  } cmd_err_t;

  typedef enum logic [1:0] {
    BE_OK       = 2'b00,
    BE_INACTIVE = 2'b01,
    BE_FUNDS    = 2'b10,
    BE_LOW      = 2'b11
  } bid_err_t;

  localparam logic [2:0] RESET_MASK = 3'b111;

  localparam logic [3:0] OP_LAST = 4'd10;

endpackage

// File: rtl/bids22_bidder_port.sv
// One bidder: owns its balance, grades its own bid, and applies loads,
// bid charges and the winning deduction when the controller enables them.
module bids22_bidder_port
  import bids22_pkg::*;
#(
  parameter int AMT_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bid,
  input  logic              retract,
  input  logic [AMT_W-1:0]  amt,
  input  logic              round_open,
  input  logic              enabled,
  input  logic [DATA_W-1:0] charge,
  input  logic [DATA_W-1:0] max_bid,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic              win_set,
  input  logic              win_clr,
  output logic              accept,
  output logic              ack,
  output bid_err_t          err,
  output logic [DATA_W-1:0] balance,
  output logic              win
);

  logic [DATA_W-1:0] balance_q, balance_d;
  logic              ack_q, ack_d, win_q, win_d;
  bid_err_t          err_q, err_d, grade;
  logic [DATA_W-1:0] amt_ext;
  logic [DATA_W:0]   need;

  assign amt_ext = {{(DATA_W-AMT_W){1'b0}}, amt};
  // 33-bit sum so a huge charge+amount cannot wrap into a false pass
  assign need    = {1'b0, charge} + {1'b0, amt_ext};

  always_comb begin
    grade = BE_OK;
    if (!round_open || !enabled)         grade = BE_INACTIVE;
    else if ({1'b0, balance_q} < need)   grade = BE_FUNDS;
    else if (amt_ext <= max_bid)         grade = BE_LOW;
  end

  // a same-cycle retract swallows the bid
  assign accept = bid && !retract && (grade == BE_OK);

  always_comb begin
    balance_d = balance_q;
    if (load_en)      balance_d = load_data;
    else if (win_set) balance_d = balance_q - max_bid;
    else if (accept)  balance_d = balance_q - charge;

    ack_d = bid | retract;
    err_d = err_q;
    if (retract)  err_d = round_open ? BE_OK : BE_INACTIVE;
    else if (bid) err_d = grade;

    win_d = win_q;
    if (win_clr)      win_d = 1'b0;
    else if (win_set) win_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      balance_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= BE_OK;
      win_q     <= 1'b0;
    end else begin
      balance_q <= balance_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      win_q     <= win_d;
    end
  end

  assign balance = balance_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign win     = win_q;

endmodule

// File: rtl/bids22_controller.sv
// BIDS22 auction controller: host command FSM (lock/unlock/cooldown/round)
// plus same-cycle bid arbitration across the X, Y, Z bidder ports.
module bids22_controller
  import bids22_pkg::*;
#(
  parameter int NBIDDERS = 3,
  parameter int AMT_W    = 16,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AMT_W-1:0]  X_bidAmt,
  input  logic [AMT_W-1:0]  Y_bidAmt,
  input  logic [AMT_W-1:0]  Z_bidAmt,
  input  logic              X_bid,
  input  logic              Y_bid,
  input  logic              Z_bid,
  input  logic              X_retract,
  input  logic              Y_retract,
  input  logic              Z_retract,
  input  logic [DATA_W-1:0] C_data,
  input  logic [3:0]        C_op,
  input  logic              C_start,
  output logic              X_ack,
  output logic              Y_ack,
  output logic              Z_ack,
  output logic [1:0]        X_err,
  output logic [1:0]        Y_err,
  output logic [1:0]        Z_err,
  output logic [DATA_W-1:0] X_balance,
  output logic [DATA_W-1:0] Y_balance,
  output logic [DATA_W-1:0] Z_balance,
  output logic              X_win,
  output logic              Y_win,
  output logic              Z_win,
  output logic              ready,
  output logic [2:0]        err,
  output logic              roundOver,
  output logic [DATA_W-1:0] maxBid
);

  state_t                state_q, state_d;
  cmd_err_t              err_q, err_d;
  logic [DATA_W-1:0]     key_q, key_d, timer_q, timer_d, charge_q, charge_d;
  logic [DATA_W-1:0]     cnt_q, cnt_d, max_q, max_d;
  logic [2:0]            mask_q, mask_d;
  logic [NBIDDERS-1:0]   leader_q, leader_d;
  logic                  ready_q, round_over_q;

  operation_t            op;
  logic                  reserved, cmd_ok, key_match, round_start, round_close, round_open;
  logic [NBIDDERS-1:0]          bid_v, ret_v, accept, load_en, win_set, ack_v, win_v;
  logic [NBIDDERS-1:0][AMT_W-1:0]  amt_v;
  logic [NBIDDERS-1:0][DATA_W-1:0] bal_v;
  logic [NBIDDERS-1:0][1:0]        berr_v;

  assign op        = operation_t'(C_op);
  assign reserved  = C_op > OP_LAST;
  assign cmd_ok    = C_start && !reserved && (state_q != ST_COOLDOWN);
  assign key_match = (C_data == key_q);

  assign bid_v = {Z_bid, Y_bid, X_bid};
  assign ret_v = {Z_retract, Y_retract, X_retract};
  assign amt_v = {Z_bidAmt, Y_bidAmt, X_bidAmt};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_UNLOCKED;
      err_q        <= CE_OK;
      key_q        <= '0;
      timer_q      <= '0;
      charge_q     <= '0;
      cnt_q        <= '0;
      max_q        <= '0;
      mask_q       <= RESET_MASK;
      leader_q     <= '0;
      ready_q      <= 1'b0;
      round_over_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      key_q        <= key_d;
      timer_q      <= timer_d;
      charge_q     <= charge_d;
      cnt_q        <= cnt_d;
      max_q        <= max_d;
      mask_q       <= mask_d;
      leader_q     <= leader_d;
      ready_q      <= (state_d != ST_COOLDOWN);
      round_over_q <= round_close;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_UNLOCKED:
        if (cmd_ok && op == OP_LOCK) state_d = ST_LOCKED;
      ST_LOCKED:
        if (cmd_ok && op == OP_UNLOCK) begin
          if (key_match) state_d = ST_UNLOCKED;
          else if (timer_q != '0) begin
            state_d = ST_COOLDOWN;
            cnt_d   = timer_q;
          end
        end else if (cmd_ok && op == OP_ROUNDACTIVE) begin
          state_d = ST_ROUND_ACTIVE;
        end
      ST_ROUND_ACTIVE:
        if (cmd_ok && op == OP_ROUNDOVER) state_d = ST_LOCKED;
      ST_COOLDOWN:
        if (cnt_q <= DATA_W'(1)) state_d = ST_LOCKED;
        else                     cnt_d   = cnt_q - DATA_W'(1);
      default: state_d = ST_UNLOCKED;
    endcase
  end

  assign round_start = cmd_ok && state_q == ST_LOCKED       && op == OP_ROUNDACTIVE;
  assign round_close = cmd_ok && state_q == ST_ROUND_ACTIVE && op == OP_ROUNDOVER;
  // bids racing the closing command are treated as outside the round
  assign round_open  = (state_q == ST_ROUND_ACTIVE) && !round_close;

  always_comb begin
    err_d = err_q;
    if (C_start) begin
      if (reserved) err_d = CE_BAD_OPCODE;
      else begin
        unique case (state_q)
          ST_UNLOCKED: case (op)
            OP_UNLOCK:                    err_d = CE_ALREADY_UNLOCKED;
            OP_ROUNDACTIVE, OP_ROUNDOVER: err_d = CE_INVALID_OP;
            default:                      err_d = CE_OK;
          endcase
          ST_LOCKED: case (op)
            OP_NOOP, OP_ROUNDACTIVE:      err_d = CE_OK;
            OP_UNLOCK:                    err_d = key_match ? CE_OK : CE_BAD_KEY;
            OP_LOCK:                      err_d = CE_ALREADY_LOCKED;
            default:                      err_d = CE_INVALID_OP;
          endcase
          ST_ROUND_ACTIVE: case (op)
            OP_NOOP, OP_ROUNDOVER:        err_d = CE_OK;
            default:                      err_d = CE_INVALID_OP;
          endcase
          default:                        err_d = CE_BUSY;
        endcase
      end
    end
  end

  always_comb begin
    key_d    = key_q;
    mask_d   = mask_q;
    timer_d  = timer_q;
    charge_d = charge_q;
    load_en  = '0;
    if (cmd_ok && state_q == ST_UNLOCKED) begin
      case (op)
        OP_LOCK:      key_d      = C_data;
        OP_SETMASK:   mask_d     = C_data[2:0];
        OP_SETTIMER:  timer_d    = C_data;
        OP_BIDCHARGE: charge_d   = C_data;
        OP_LOADX:     load_en[0] = 1'b1;
        OP_LOADY:     load_en[1] = 1'b1;
        OP_LOADZ:     load_en[2] = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    logic             found;
    logic [AMT_W-1:0] best;
    logic [NBIDDERS-1:0] best_oh;
    found    = 1'b0;
    best     = '0;
    best_oh  = '0;
    // strict > keeps the lower index on ties, giving X > Y > Z
    for (int i = 0; i < NBIDDERS; i++) begin
      if (accept[i] && (!found || amt_v[i] > best)) begin
        found      = 1'b1;
        best       = amt_v[i];
        best_oh    = '0;
        best_oh[i] = 1'b1;
      end
    end

    leader_d = leader_q;
    max_d    = max_q;
    if (round_start) begin
      leader_d = '0;
      max_d    = '0;
    end else if (round_close) begin
      if (leader_q == '0) max_d = '0;
    end else begin
      if (|(ret_v & leader_q) && round_open) begin
        leader_d = '0;
        max_d    = '0;
      end
      if (found) begin
        leader_d = best_oh;
        max_d    = {{(DATA_W-AMT_W){1'b0}}, best};
      end
    end
  end

  assign win_set = round_close ? leader_q : '0;

  for (genvar g = 0; g < NBIDDERS; g++) begin : g_port
    bids22_bidder_port #(.AMT_W(AMT_W), .DATA_W(DATA_W)) u_port (
      .clk        (clk),
      .reset      (reset),
      .bid        (bid_v[g]),
      .retract    (ret_v[g]),
      .amt        (amt_v[g]),
      .round_open (round_open),
      .enabled    (mask_q[g]),
      .charge     (charge_q),
      .max_bid    (max_q),
      .load_en    (load_en[g]),
      .load_data  (C_data),
      .win_set    (win_set[g]),
      .win_clr    (round_start),
      .accept     (accept[g]),
      .ack        (ack_v[g]),
      .err        (berr_v[g]),
      .balance    (bal_v[g]),
      .win        (win_v[g])
    );
  end

  assign {Z_ack, Y_ack, X_ack} = ack_v;
  assign {Z_win, Y_win, X_win} = win_v;
  assign X_err     = berr_v[0];
  assign Y_err     = berr_v[1];
  assign Z_err     = berr_v[2];
  assign X_balance = bal_v[0];
  assign Y_balance = bal_v[1];
  assign Z_balance = bal_v[2];
  assign ready     = ready_q;
  assign err       = err_q;
  assign roundOver = round_over_q;
  assign maxBid    = max_q;

endmodule

// File: doc/bids22_controller.md
Name: bids22_controller

Overview:
- Three-bidder (X, Y, Z) auction controller; the DUT end of the BIDS22 interface the tester/BFM drives.
- A host control port carries opcodes with C_data, qualified by C_start. It manages lock state, balances, bidder mask, cooldown timer and bid charge.
- During an active round it arbitrates bids and retracts.
- It reports per-bidder ack/err/balance/win and global ready/err/roundOver/maxBid.

Parameters:
- NBIDDERS, 3, number of bidder ports (fixed X,Y,Z; documentation only)
- AMT_W, 16, bid amount width
- DATA_W, 32, C_data/balance/maxBid width

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high
- X_bidAmt/Y_bidAmt/Z_bidAmt  in  16  bid amounts
- X_bid/Y_bid/Z_bid  in  1  bid strobe (one cycle)
- X_retract/Y_retract/Z_retract  in  1  retract strobe
- C_data  in  32  command operand
- C_op  in  4  operation_t
- C_start  in  1  command strobe
- X_ack/Y_ack/Z_ack  out  1  one-cycle response pulse
- X_err/Y_err/Z_err  out  2  per-bidder status
- X_balance/Y_balance/Z_balance  out  32  current balances
- X_win/Y_win/Z_win  out  1  round winner flag
- ready  out  1  accepting commands
- err  out  3  command status
- roundOver  out  1  one-cycle pulse at round close
- maxBid  out  32  current/final highest bid, zero-extended

Behaviour:
- All outputs registered. Commands and bids take effect, and respond, exactly 1 cycle after the strobe.
- Reset (reset=1 at clk edge):
  - Outputs: all 0 (ready=0).
  - Internal: state=UNLOCKED, mask=3'b111, key=0, timer=0, charge=0, balances=0.
  - ready=1 on the first edge with reset=0.
  - Reset mid-round aborts the round: no win, no roundOver.
- C_op encoding:
  - 0 NoOp, 1 Unlock, 2 Lock, 3 LoadX, 4 LoadY, 5 LoadZ, 6 SetMask, 7 SetTimer, 8 BidCharge, 9 RoundActive, 10 RoundOver.
  - 11-15 are reserved.
- err codes (updated only on C_start, held otherwise):
  - 000 OK, 001 BadKey, 010 AlreadyUnlocked, 011 AlreadyLocked, 100 InvalidOp, 101 Busy, 110 BadOpcode.
- FSM states: UNLOCKED, LOCKED, ROUND_ACTIVE, COOLDOWN.
- UNLOCKED:
  - LoadX/Y/Z: balance=C_data.
  - SetMask: mask=C_data[2:0] (bit0=X).
  - SetTimer: timer=C_data.
  - BidCharge: charge=C_data.
  - Lock: key=C_data, ->LOCKED.
  - Unlock: err=010. RoundActive/RoundOver: err=100.
- LOCKED:
  - Unlock with C_data==key: ->UNLOCKED.
  - Unlock with mismatch: err=001. Goes ->COOLDOWN with counter=timer, or stays LOCKED if timer==0.
  - RoundActive: clears maxBid, leader and all win flags, ->ROUND_ACTIVE.
  - Lock: err=011. Loads/Set*/RoundOver: err=100.
- ROUND_ACTIVE:
  - RoundOver: leader's balance -= maxBid; leader's win=1; roundOver=1 for one cycle; ->LOCKED.
  - With no leader, RoundOver gives no win and maxBid=0.
  - Any other op: err=100.
- COOLDOWN:
  - ready=0; the counter decrements each cycle; at count 1 the next state is LOCKED, with ready=1 in the same cycle.
  - Any C_start: err=101, no effect.
- NoOp: err=000 in every state except COOLDOWN.
- Reserved op: err=110 in every state, with no state change.
- Bids:
  - Every bid or retract strobe produces an ack pulse next cycle.
  - Bidder err codes: 00 accepted, 01 round inactive or bidder masked, 10 insufficient funds (balance < charge+amount, 33-bit compare), 11 amount <= maxBid.
  - Accepted bid: balance -= charge.
  - Among the same-cycle accepted bids, the highest amount becomes leader and maxBid. Ties resolve X>Y>Z.
- Retracts:
  - Retract by the leader clears leader and maxBid=0. Retract by a non-leader has no effect. Both report err=00.
  - Retract outside a round: err=01.
  - Bid and retract from the same bidder in the same cycle: retract wins, the bid is ignored (single ack).
- Arithmetic: balances never wrap; the checks above prevent underflow.

Decomposition:
- BIDS22pkg holds:
  - operation_t with the encodings above.
  - state_t.
  - cmd_err_t (3-bit) and bid_err_t (2-bit) enums.
  - Constant RESET_MASK=3'b111.
- Sub-module bids22_bidder_port, instantiated 3x. It holds its balance, evaluates its bid err, and applies charge and win deduction under controller enables.

Test Plan:
- Reset, then one idle cycle -> ready=1, err=000, all balances=0, state UNLOCKED.
- LoadX 0x100, BidCharge 0x10, Lock key 0xAB, RoundActive; X_bid amt 0x50 -> X_ack, X_err=00, X_balance=0xF0, maxBid=0x50.
- Continue: RoundOver -> roundOver pulse, X_win=1, X_balance=0xA0.
- Unlock with 0xAC while timer=5 -> err=001, ready=0 for 5 cycles. A C_start during that window gives err=101. Unlock 0xAB afterwards -> UNLOCKED.
- Round with charge=0, X/Y/Z balances 0x1000:
  - Same-cycle bids X=0x20, Y=0x20, Z=0x10 -> leader X, maxBid=0x20.
  - Z bid 0x20 -> Z_err=11.
- SetMask 3'b101; in round, Y_bid -> Y_err=01. X with balance 0x10, charge 0x10, bid 1 -> X_err=10. X retract as leader -> maxBid=0.
